// File: rtl/ucie_sb_rx_deser.sv
// UCIe sideband receive deserializer: collects 64 serial bits MSB first, checks
// even parity and enforces inter-packet gap; good packets go to a 2-entry FIFO.
module ucie_sb_rx_deser #(
    parameter int unsigned MIN_GAP     = 32,
    parameter int unsigned BIT_TIMEOUT = 16
) (
    input  logic        aux_clk,
    input  logic        aux_rst,
    input  logic        sb_bit_valid,
    input  logic        sb_data_in,
    output logic        rx_packet_valid,
    output logic [63:0] rx_packet_data,
    output logic [3:0]  rx_packet_type,
    output logic [7:0]  rx_packet_length,
    input  logic        rx_packet_ready,
    output logic        sideband_active,
    output logic        sideband_error,
    output logic [7:0]  sideband_status,
    input  logic        status_clr
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        GAP  = 3'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] shift_q, shift_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [63:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic        ovf_q, ovf_d, par_q, par_d, frm_q, frm_d;
    logic        err_q, err_d;

    logic push, pop, push_ok, set_ovf, set_par, set_frm;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        mem0_d    = mem0_q;
        mem1_d    = mem1_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        push      = 1'b0;
        push_ok   = 1'b0;
        set_ovf   = 1'b0;
        set_par   = 1'b0;
        set_frm   = 1'b0;
        pop       = rx_packet_valid && rx_packet_ready;

        case (state_q)
            IDLE: begin
                if (sb_bit_valid) begin
                    shift_d   = {shift_q[62:0], sb_data_in};
                    bit_cnt_d = 7'd1;
                    tmo_cnt_d = '0;
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (sb_bit_valid) begin
                    shift_d   = {shift_q[62:0], sb_data_in};
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 7'd63) begin
                        // XOR over all 64 bits is zero exactly when bit 0 is the even parity of [63:1]
                        if (^shift_d == 1'b0) push = 1'b1;
                        else                  set_par = 1'b1;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end else if (tmo_cnt_q + 16'd1 == 16'(BIT_TIMEOUT)) begin
                    set_frm   = 1'b1;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (sb_bit_valid) begin
                    set_frm   = 1'b1;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q + 16'd1 == 16'(MIN_GAP)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) rd_ptr_d = ~rd_ptr_q;
        if (push) begin
            if (fifo_cnt_q == 2'd2 && !pop) begin
                set_ovf = 1'b1;
            end else begin
                push_ok  = 1'b1;
                wr_ptr_d = ~wr_ptr_q;
                if (wr_ptr_q) mem1_d = shift_d;
                else          mem0_d = shift_d;
            end
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, push_ok} - {1'b0, pop};

        ovf_d = (ovf_q & ~status_clr) | set_ovf;
        par_d = (par_q & ~status_clr) | set_par;
        frm_d = (frm_q & ~status_clr) | set_frm;
        err_d = set_ovf | set_par | set_frm;
    end

    always_ff @(posedge aux_clk or posedge aux_rst) begin
        if (aux_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            mem0_q     <= '0;
            mem1_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
            par_q      <= 1'b0;
            frm_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
            par_q      <= par_d;
            frm_q      <= frm_d;
            err_q      <= err_d;
        end
    end

    assign rx_packet_valid  = (fifo_cnt_q != 2'd0);
    assign rx_packet_data   = rx_packet_valid ? (rd_ptr_q ? mem1_q : mem0_q) : '0;
    assign rx_packet_type   = rx_packet_data[63:60];
    assign rx_packet_length = rx_packet_data[59:52];
    assign sideband_active  = (state_q == RECV);
    assign sideband_error   = err_q;
    assign sideband_status  = {ovf_q, par_q, frm_q, fifo_cnt_q, state_q};

endmodule

// File: tb/tb_ucie_sb_rx_deser.sv
// Bench for ucie_sb_rx_deser: queue-based packet model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ucie_sb_rx_deser;

    localparam int MIN_GAP     = 32;
    localparam int BIT_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        din = 1'b0;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic        valid;
    logic [63:0] data;
    logic [3:0]  ptype;
    logic [7:0]  plen;
    logic        active;
    logic        err;
    logic [7:0]  status;

    int total = 0;
    int bad   = 0;

    ucie_sb_rx_deser #(.MIN_GAP(MIN_GAP), .BIT_TIMEOUT(BIT_TIMEOUT)) dut (
        .aux_clk          (clk),
        .aux_rst          (rst),
        .sb_bit_valid     (stb),
        .sb_data_in       (din),
        .rx_packet_valid  (valid),
        .rx_packet_data   (data),
        .rx_packet_type   (ptype),
        .rx_packet_length (plen),
        .rx_packet_ready  (rdy),
        .sideband_active  (active),
        .sideband_error   (err),
        .sideband_status  (status),
        .status_clr       (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle / 1 receiving / 2 gap, bits collected in acc, FIFO as a queue.
    int          m_mode = 0;
    int          m_n    = 0;
    int          m_run  = 0;
    logic [63:0] m_acc  = '0;
    logic [63:0] m_fifo[$];
    logic        m_ovf = 0, m_par = 0, m_frm = 0, m_err = 0;
    logic        e, have, do_pop;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = 0; m_n = 0; m_run = 0; m_acc = '0;
            m_fifo.delete();
            m_ovf = 0; m_par = 0; m_frm = 0; m_err = 0;
        end else begin
            e = 0; have = 0;
            do_pop = (m_fifo.size() > 0) && rdy;
            if (clr) begin m_ovf = 0; m_par = 0; m_frm = 0; end
            if (m_mode == 0) begin
                if (stb) begin m_acc = {63'b0, din}; m_n = 1; m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (stb) begin
                    m_acc = {m_acc[62:0], din}; m_n++; m_run = 0;
                    if (m_n == 64) begin
                        if (^m_acc == 1'b0) have = 1;
                        else begin m_par = 1; e = 1; end
                        m_mode = 2;
                    end
                end else begin
                    m_run++;
                    if (m_run == BIT_TIMEOUT) begin m_frm = 1; e = 1; m_mode = 0; end
                end
            end else begin
                if (stb) begin m_frm = 1; e = 1; m_run = 0; end
                else begin
                    m_run++;
                    if (m_run == MIN_GAP) begin m_mode = 0; m_run = 0; end
                end
            end
            if (do_pop) void'(m_fifo.pop_front());
            if (have) begin
                if (m_fifo.size() < 2) m_fifo.push_back(m_acc);
                else begin m_ovf = 1; e = 1; end
            end
            m_err = e;
        end
    end

    always @(negedge clk) begin
        logic [63:0] hd;
        logic [1:0]  sz;
        sz = 2'(m_fifo.size());
        hd = (m_fifo.size() > 0) ? m_fifo[0] : 64'h0;
        chk("valid",  {63'b0, valid}, {63'b0, m_fifo.size() > 0});
        chk("data",   data, hd);
        chk("type",   {60'b0, ptype}, {60'b0, hd[63:60]});
        chk("length", {56'b0, plen}, {56'b0, hd[59:52]});
        chk("active", {63'b0, active}, {63'b0, m_mode == 1});
        chk("error",  {63'b0, err}, {63'b0, m_err});
        chk("status", {56'b0, status}, {56'b0, m_ovf, m_par, m_frm, sz, 3'(m_mode)});
    end

    function automatic logic [63:0] mkpkt(input logic [63:0] x);
        logic [62:0] hi;
        hi = x[63:1];
        return {hi, ^hi};
    endfunction

    task automatic put_bit(input logic b);
        stb = 1'b1; din = b;
        @(posedge clk); #2;
        stb = 1'b0;
    endtask

    task automatic send(input logic [63:0] p, input int nbits);
        for (int i = 63; i > 63 - nbits; i--) put_bit(p[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #2;
        clr = 1'b0;
    endtask

    localparam logic [63:0] PA = 64'h5A10_0000_0000_0001;
    logic [63:0] p1, p2, p3, pbad;

    initial begin
        p1 = mkpkt(64'h1234_5678_9ABC_DEF0);
        p2 = mkpkt(64'hC0FF_EE00_1122_3345);
        p3 = mkpkt(64'h8765_4321_0F0F_F0F1);
        pbad = PA ^ 64'h1;

        idle(2);
        chk("rst_status", {56'b0, status}, 64'h0);
        chk("rst_valid", {63'b0, valid}, 64'h0);
        rst = 1'b0;
        idle(2);

        // Clean packet consumed immediately
        rdy = 1'b1;
        send(PA, 64);
        chk("a_valid", {63'b0, valid}, 64'h1);
        chk("a_type", {60'b0, ptype}, 64'h5);
        chk("a_len", {56'b0, plen}, 64'hA1);
        chk("a_err", {63'b0, err}, 64'h0);
        idle(1);
        chk("a_popped", {63'b0, valid}, 64'h0);
        idle(40);

        // Parity error
        send(pbad, 64);
        chk("par_valid", {63'b0, valid}, 64'h0);
        chk("par_err", {63'b0, err}, 64'h1);
        chk("par_bit6", {63'b0, status[6]}, 64'h1);
        idle(1);
        do_clr();
        chk("par_clr", {63'b0, status[6]}, 64'h0);
        idle(40);

        // Bit timeout mid-packet, then clean packet
        send(p1, 30);
        idle(15);
        chk("tmo_still_recv", {61'b0, status[2:0]}, 64'h1);
        idle(1);
        chk("tmo_frm", {63'b0, status[5]}, 64'h1);
        chk("tmo_idle", {61'b0, status[2:0]}, 64'h0);
        do_clr();
        rdy = 1'b0;
        send(p1, 64);
        chk("tmo_next", data, p1);
        rdy = 1'b1;
        idle(40);

        // Overflow: three packets, consumer stalled
        rdy = 1'b0;
        send(p1, 64); idle(MIN_GAP);
        send(p2, 64); idle(MIN_GAP);
        send(p3, 64);
        chk("ovf_err", {63'b0, err}, 64'h1);
        chk("ovf_bit7", {63'b0, status[7]}, 64'h1);
        chk("ovf_cnt", {62'b0, status[4:3]}, 64'h2);
        chk("ovf_head1", data, p1);
        rdy = 1'b1;
        idle(1);
        chk("ovf_head2", data, p2);
        idle(1);
        chk("ovf_empty", {63'b0, valid}, 64'h0);
        idle(MIN_GAP);
        do_clr();

        // Strobe during gap restarts the gap count
        send(PA, 64);
        idle(10);
        chk("gap_state", {61'b0, status[2:0]}, 64'h2);
        put_bit(1'b1);
        chk("gap_err", {63'b0, err}, 64'h1);
        chk("gap_frm", {63'b0, status[5]}, 64'h1);
        idle(MIN_GAP - 1);
        chk("gap_hold", {61'b0, status[2:0]}, 64'h2);
        idle(1);
        chk("gap_idle", {61'b0, status[2:0]}, 64'h0);
        do_clr();

        // Reset mid-packet with a packet held in the FIFO
        rdy = 1'b0;
        send(PA, 64);
        idle(MIN_GAP);
        send(p2, 24);
        chk("pre_rst_valid", {63'b0, valid}, 64'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {63'b0, valid}, 64'h0);
        chk("rst_mid_data", data, 64'h0);
        chk("rst_mid_status", {56'b0, status}, 64'h0);
        chk("rst_mid_active", {63'b0, active}, 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        idle(1);
        rdy = 1'b1;
        send(p3, 64);
        chk("post_rst_valid", {63'b0, valid}, 64'h1);
        chk("post_rst_data", data, p3);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
